// File: rtl/fact_ram_master.sv
// rtl/fact_ram_master.sv - single-port RAM master: write, read, clear-all, reserved no-op
// All RAM-facing and response outputs are registered; req_ready/busy decode the state register.
module fact_ram_master #(
  parameter int                   ADDR_W    = 8,
  parameter int                   DATA_W    = 64,
  parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_CLR} state_t;

  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t              state_q;
  logic [ADDR_W:0]     clr_cnt_q;
  logic [ADDR_W:0]     clr_cnt_d;
  logic                ram_cen_q;
  logic                ram_wen_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                accept;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign clr_cnt_d = clr_cnt_q + 1'b1;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ram_cen   = ram_cen_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= '0;
      ram_cen_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              2'b00: begin
                state_q    <= S_RD;
                ram_cen_q  <= 1'b1;
                ram_wen_q  <= 1'b0;
                ram_addr_q <= req_addr;
              end
              2'b01: begin
                state_q    <= S_WR;
                ram_cen_q  <= 1'b1;
                ram_wen_q  <= 1'b1;
                ram_addr_q <= req_addr;
                ram_din_q  <= req_wdata;
              end
              2'b10: begin
                state_q    <= S_CLR;
                clr_cnt_q  <= '0;
                ram_cen_q  <= 1'b1;
                ram_wen_q  <= 1'b1;
                ram_addr_q <= '0;
                ram_din_q  <= CLR_VALUE;
              end
              default: ;
            endcase
          end
        end
        S_WR: begin
          state_q    <= S_IDLE;
          ram_cen_q  <= 1'b0;
          ram_wen_q  <= 1'b0;
          ram_addr_q <= '0;
          ram_din_q  <= '0;
        end
        S_RD: begin
          state_q    <= S_RDW;
          ram_cen_q  <= 1'b0;
          ram_addr_q <= '0;
        end
        S_RDW: begin
          // RAM data for the address presented in RD is valid during this cycle
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ram_dout;
        end
        S_CLR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            ram_cen_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
          end else begin
            clr_cnt_q  <= clr_cnt_d;
            ram_addr_q <= clr_cnt_d[ADDR_W-1:0];
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ram_cen_q <= 1'b0;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
